ysyx_22040210_div_ctrl: RTL and testbench
=========================================

Name: ysyx_22040210_div_ctrl

Overview:
- Initiator side of the divider request/response interface; sits in the MDU between EXU issue and the unsigned pipelined divider.
- Accepts RISC-V DIV/DIVU/REM/REMU and their W forms, and converts the operands to unsigned magnitudes.
- Resolves divide-by-zero and signed overflow locally, because the divider never answers a zero divisor.
- Issues one request at a time, collects the quotient/remainder, applies sign fix-up, and returns the result to the pipeline with valid/ready backpressure.

Parameters:
- WIDTH, 64, datapath width. W forms operate on bits [31:0].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mdu_valid_i  in  1  request valid from EXU
- mdu_ready_o  out  1  controller can accept a request
- mdu_op_i  in  2  operation code: DIV=0, DIVU=1, REM=2, REMU=3
- mdu_word_i  in  1  W form (32-bit op, sign-extended result)
- mdu_src1_i  in  WIDTH  dividend
- mdu_src2_i  in  WIDTH  divisor
- flush_i  in  1  pipeline flush; discard in-flight op
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer takes result
- result_o  out  WIDTH  final result
- mdu_busy_o  out  1  state != IDLE
- div_datavalid_o  out  1  one-cycle request pulse to divider
- div_dividend_o  out  WIDTH  unsigned dividend magnitude
- div_divisor_o  out  WIDTH  unsigned divisor magnitude (never 0 when issued)
- div_ready_o  out  1  one-cycle ack that clears divider result
- div_doing_i  in  1  divider busy (status only)
- div_qrvalid_i  in  1  divider result valid; level, held until ack
- div_quotient_i  in  WIDTH  unsigned quotient
- div_remainder_i  in  WIDTH  unsigned remainder

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except mdu_ready_o=1; operand and result registers 0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. mdu_ready_o = (state==IDLE) & ~flush_i.
- Accept = mdu_valid_i & mdu_ready_o.
- Operand preparation on accept:
  - W forms: src1/src2 low 32 bits are sign-extended (DIV/REM) or zero-extended (DIVU/REMU).
  - Signed ops: take two's-complement magnitude; latch neg_q = sign1^sign2 and neg_r = sign1.
- Special cases (no divider request):
  - Divisor == 0: q = all ones; r = extended dividend.
  - Signed op with dividend == MIN and divisor == -1 (MIN per width): q = dividend; r = 0.
  - On accept, the result is registered and state goes IDLE->DONE. result_valid_o is high in cycle T+1.
- Normal path:
  - IDLE->ISSUE: magnitudes are registered into div_dividend_o/div_divisor_o.
  - ISSUE: div_datavalid_o=1 for exactly one cycle, then ->WAIT.
  - div_dividend_o/div_divisor_o must stay stable from ISSUE until the ack cycle, because the divider samples them late.
- WAIT: when div_qrvalid_i=1:
  - div_ready_o=1 combinationally that cycle.
  - Capture the fixed-up result: q negated if neg_q; r negated if neg_r; W forms sign-extend bit 31 of the selected value.
  - ->DONE.
- DONE: result_valid_o=1 and result_o held stable until result_ready_i. On handshake ->IDLE; the next request can be accepted in the following cycle.
- Flush:
  - In DONE: drop the result, ->IDLE.
  - In ISSUE or WAIT: ->DRAIN.
  - In DRAIN: wait for div_qrvalid_i, pulse div_ready_o, discard, ->IDLE. result_valid_o is never raised for a flushed op.
  - Flush in the same cycle as mdu_valid_i in IDLE: no accept.
- Flush and div_qrvalid_i in the same WAIT cycle: ack the divider, discard the result, ->IDLE.
- div_datavalid_o is never asserted while div_qrvalid_i=1 or outside ISSUE.
- div_ready_o is never asserted in any state other than WAIT or DRAIN.
- Reset mid-operation returns to IDLE immediately. The divider shares rst, so no drain is needed.

Decomposition:
- Op-code values (DIV/DIVU/REM/REMU) and FSM state encodings go in the shared ysyx_22040210_define include.
- One combinational sub-module, ysyx_22040210_div_fixup: operand extension, magnitude, special-case detection, and result sign correction. The FSM stays in the top module.

Test Plan:
- DIV, src1=-7, src2=2 via behavioural divider model -> result_o=0xFFFFFFFFFFFFFFFD (-3); one datavalid pulse; one div_ready pulse.
- REM, src1=-7, src2=2 -> result_o=0xFFFFFFFFFFFFFFFF (-1). REMU, src1=7, src2=0 -> result_o=7, result_valid_o at T+1, no div_datavalid_o.
- DIV, src1=0x8000000000000000, src2=-1 -> result 0x8000000000000000. REM with the same operands -> 0. Neither issues a divider request.
- DIVW, src1=0x12345678_80000000, src2=0xFFFFFFFF_FFFFFFFF -> result 0xFFFFFFFF80000000 (overflow path). DIVUW, src1=0xFFFFFFFF, src2=2 -> result 0x000000007FFFFFFF.
- Flush asserted 2 cycles into WAIT:
  - No result_valid_o.
  - Divider result later acked with a single div_ready_o pulse, then mdu_ready_o=1.
  - A following DIVU 100/7 returns 14.
- Hold result_ready_i=0 for 5 cycles in DONE -> result_valid_o and result_o stable, mdu_ready_o=0. Assert rst mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ysyx_22040210_div_ctrl_pkg.sv
// ysyx_22040210_div_ctrl_pkg: op codes, FSM states and op decode helpers shared by the divider controller.
package ysyx_22040210_div_ctrl_pkg;
  localparam int XLEN = 64;
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_e;
  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_DIV) | (op == OP_REM);
  endfunction
  function automatic logic op_rem(input logic [1:0] op);
    return (op == OP_REM) | (op == OP_REMU);
  endfunction
endpackage

// File: rtl/ysyx_22040210_div_fixup.sv
// ysyx_22040210_div_fixup: operand extension/magnitude, zero-divisor and overflow detection, result sign fix-up.
module ysyx_22040210_div_fixup
  import ysyx_22040210_div_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [1:0]       op_i,
  input  logic             word_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] dividend_o,
  output logic [WIDTH-1:0] divisor_o,
  output logic             neg_q_o,
  output logic             neg_r_o,
  output logic             special_o,
  output logic [WIDTH-1:0] special_res_o,
  input  logic             rem_i,
  input  logic             word_res_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  input  logic [WIDTH-1:0] quotient_i,
  input  logic [WIDTH-1:0] remainder_i,
  output logic [WIDTH-1:0] result_o
);
  function automatic logic [WIDTH-1:0] wext(input logic w, input logic [WIDTH-1:0] v);
    return w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
  endfunction
  logic             sgn, s1, s2, div0, ovf;
  logic [WIDTH-1:0] a, b, min_v, sp_sel, fsel, fval;
  assign sgn = op_signed(op_i);
  assign a = word_i ? {{(WIDTH-32){sgn & src1_i[31]}}, src1_i[31:0]} : src1_i;
  assign b = word_i ? {{(WIDTH-32){sgn & src2_i[31]}}, src2_i[31:0]} : src2_i;
  // most negative value of the operating width, already sign-extended for W forms
  assign min_v = word_i ? {{(WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(WIDTH-1){1'b0}}};
  assign s1 = sgn & a[WIDTH-1];
  assign s2 = sgn & b[WIDTH-1];
  assign dividend_o = s1 ? -a : a;
  assign divisor_o = s2 ? -b : b;
  assign neg_q_o = s1 ^ s2;
  assign neg_r_o = s1;
  assign div0 = b == '0;
  assign ovf = sgn & (a == min_v) & (b == '1);
  assign special_o = div0 | ovf;
  assign sp_sel = op_rem(op_i) ? (div0 ? a : '0) : (div0 ? '1 : a);
  assign special_res_o = wext(word_i, sp_sel);
  assign fsel = rem_i ? remainder_i : quotient_i;
  assign fval = (rem_i ? neg_r_i : neg_q_i) ? -fsel : fsel;
  assign result_o = wext(word_res_i, fval);
endmodule

// File: rtl/ysyx_22040210_div_ctrl.sv
// ysyx_22040210_div_ctrl: MDU-side initiator for the unsigned divider; one op in flight,
// local handling of zero divisor and signed overflow, flush drains any outstanding divider result.
module ysyx_22040210_div_ctrl
  import ysyx_22040210_div_ctrl_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mdu_valid_i,
  output logic             mdu_ready_o,
  input  logic [1:0]       mdu_op_i,
  input  logic             mdu_word_i,
  input  logic [WIDTH-1:0] mdu_src1_i,
  input  logic [WIDTH-1:0] mdu_src2_i,
  input  logic             flush_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             mdu_busy_o,
  output logic             div_datavalid_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  output logic             div_ready_o,
  input  logic             div_doing_i,
  input  logic             div_qrvalid_i,
  input  logic [WIDTH-1:0] div_quotient_i,
  input  logic [WIDTH-1:0] div_remainder_i
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d, result_q, result_d;
  logic             rem_q, rem_d, word_q, word_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [WIDTH-1:0] fx_dividend, fx_divisor, fx_special_res, fx_result;
  logic             fx_neg_q, fx_neg_r, fx_special, accept;
  ysyx_22040210_div_fixup #(.WIDTH(WIDTH)) u_fixup (
    .op_i          (mdu_op_i),
    .word_i        (mdu_word_i),
    .src1_i        (mdu_src1_i),
    .src2_i        (mdu_src2_i),
    .dividend_o    (fx_dividend),
    .divisor_o     (fx_divisor),
    .neg_q_o       (fx_neg_q),
    .neg_r_o       (fx_neg_r),
    .special_o     (fx_special),
    .special_res_o (fx_special_res),
    .rem_i         (rem_q),
    .word_res_i    (word_q),
    .neg_q_i       (neg_q_q),
    .neg_r_i       (neg_r_q),
    .quotient_i    (div_quotient_i),
    .remainder_i   (div_remainder_i),
    .result_o      (fx_result)
  );
  assign mdu_ready_o = (state_q == S_IDLE) & ~flush_i;
  assign accept = mdu_valid_i & mdu_ready_o;
  assign mdu_busy_o = state_q != S_IDLE;
  assign result_valid_o = state_q == S_DONE;
  assign result_o = result_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o = divisor_q;
  always_comb begin
    state_d = state_q;
    dividend_d = dividend_q;
    divisor_d = divisor_q;
    result_d = result_q;
    rem_d = rem_q;
    word_d = word_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    div_datavalid_o = 1'b0;
    div_ready_o = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        rem_d = op_rem(mdu_op_i);
        word_d = mdu_word_i;
        neg_q_d = fx_neg_q;
        neg_r_d = fx_neg_r;
        result_d = fx_special ? fx_special_res : result_q;
        dividend_d = fx_special ? dividend_q : fx_dividend;
        divisor_d = fx_special ? divisor_q : fx_divisor;
        state_d = fx_special ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        // hold the request back while a stale result or busy divider is still visible
        div_datavalid_o = ~div_qrvalid_i & ~div_doing_i;
        state_d = div_datavalid_o ? (flush_i ? S_DRAIN : S_WAIT) : (flush_i ? S_IDLE : S_ISSUE);
      end
      S_WAIT: begin
        div_ready_o = div_qrvalid_i;
        result_d = (div_qrvalid_i & ~flush_i) ? fx_result : result_q;
        state_d = div_qrvalid_i ? (flush_i ? S_IDLE : S_DONE) : (flush_i ? S_DRAIN : S_WAIT);
      end
      S_DONE: state_d = (flush_i | result_ready_i) ? S_IDLE : S_DONE;
      S_DRAIN: begin
        div_ready_o = div_qrvalid_i;
        state_d = div_qrvalid_i ? S_IDLE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dividend_q <= '0;
      divisor_q <= '0;
      result_q <= '0;
      rem_q <= 1'b0;
      word_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dividend_q <= dividend_d;
      divisor_q <= divisor_d;
      result_q <= result_d;
      rem_q <= rem_d;
      word_q <= word_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22040210_div_ctrl.sv
// tb_ysyx_22040210_div_ctrl: table vectors, flush/backpressure/reset sequences and random ops
// checked against RISC-V division semantics, with a latency-randomised divider model.
module tb_ysyx_22040210_div_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdu_valid_i = 1'b0, mdu_word_i = 1'b0, flush_i = 1'b0, result_ready_i = 1'b0;
  logic [1:0]  mdu_op_i = 2'd0;
  logic [63:0] mdu_src1_i = '0, mdu_src2_i = '0;
  logic        mdu_ready_o, result_valid_o, mdu_busy_o, div_datavalid_o, div_ready_o;
  logic [63:0] result_o, div_dividend_o, div_divisor_o;
  logic        div_doing_i, div_qrvalid_i;
  logic [63:0] div_quotient_i, div_remainder_i;
  int total = 0, bad = 0, dv_cnt = 0, rd_cnt = 0, force_lat = -1;
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_a, m_b;

  always #5 clk = ~clk;

  ysyx_22040210_div_ctrl dut (
    .clk(clk), .rst(rst), .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
    .mdu_op_i(mdu_op_i), .mdu_word_i(mdu_word_i), .mdu_src1_i(mdu_src1_i), .mdu_src2_i(mdu_src2_i),
    .flush_i(flush_i), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .mdu_busy_o(mdu_busy_o), .div_datavalid_o(div_datavalid_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o), .div_ready_o(div_ready_o),
    .div_doing_i(div_doing_i), .div_qrvalid_i(div_qrvalid_i),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i)
  );

  assign div_doing_i = m_busy & ~div_qrvalid_i;

  always @(posedge clk) begin
    if (div_datavalid_o) dv_cnt++;
    if (div_ready_o) rd_cnt++;
  end

  // unsigned divider model: random latency, level result held until acknowledged
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_qrvalid_i <= 1'b0;
      div_quotient_i <= '0;
      div_remainder_i <= '0;
      m_busy <= 1'b0;
      m_cnt <= 0;
      m_a <= '0;
      m_b <= '0;
    end else begin
      if (div_datavalid_o) begin
        if (div_qrvalid_i || m_busy || div_divisor_o == 64'd0) begin
          bad++;
          $display("FAIL proto_issue qrvalid=%0b busy=%0b divisor=%h", div_qrvalid_i, m_busy, div_divisor_o);
        end
        m_busy <= 1'b1;
        m_a <= div_dividend_o;
        m_b <= div_divisor_o;
        m_cnt <= force_lat >= 0 ? force_lat : int'($urandom_range(0, 5));
      end else if (m_busy && !div_qrvalid_i) begin
        if (m_cnt == 0) begin
          div_qrvalid_i <= 1'b1;
          div_quotient_i <= m_a / m_b;
          div_remainder_i <= m_a % m_b;
        end else m_cnt <= m_cnt - 1;
      end
      if (m_busy && (div_dividend_o != m_a || div_divisor_o != m_b)) begin
        bad++;
        $display("FAIL operand_stable got=%h/%h exp=%h/%h", div_dividend_o, div_divisor_o, m_a, m_b);
      end
      if (div_ready_o && !div_qrvalid_i) begin
        bad++;
        $display("FAIL proto_ack div_ready_o without div_qrvalid_i");
      end
      if (div_qrvalid_i && div_ready_o) begin
        div_qrvalid_i <= 1'b0;
        m_busy <= 1'b0;
      end
    end
  end

  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
    logic sg, rm;
    logic [31:0] a32, b32, q32, r32, v32;
    logic [63:0] q, r;
    sg = !op[0];
    rm = op[1];
    if (w) begin
      a32 = s1[31:0];
      b32 = s2[31:0];
      if (b32 == 0) begin q32 = '1; r32 = a32; end
      else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
      else if (sg) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      v32 = rm ? r32 : q32;
      return {{32{v32[31]}}, v32};
    end
    if (s2 == 0) begin q = '1; r = s1; end
    else if (sg && s1 == 64'h8000_0000_0000_0000 && s2 == '1) begin q = s1; r = 0; end
    else if (sg) begin q = $signed(s1) / $signed(s2); r = $signed(s1) % $signed(s2); end
    else begin q = s1 / s2; r = s1 % s2; end
    return rm ? r : q;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
    int n;
    n = 0;
    @(negedge clk);
    while (!mdu_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mdu_ready_o) chk("send_timeout", {63'd0, mdu_ready_o}, 64'd1);
    mdu_valid_i = 1'b1;
    mdu_op_i = op;
    mdu_word_i = w;
    mdu_src1_i = s1;
    mdu_src2_i = s2;
    @(negedge clk);
    mdu_valid_i = 1'b0;
  endtask

  task automatic get(output logic [63:0] res, input int hold);
    int n;
    n = 0;
    while (!result_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid_o) chk("result_timeout", {63'd0, result_valid_o}, 64'd1);
    res = result_o;
    repeat (hold) @(negedge clk);
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] s1, s2, exp;
    logic        sp;
  } vec_t;
  vec_t tv[10];

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return $urandom_range(0, 1) ? 64'($urandom_range(1, 20)) : -64'($urandom_range(1, 20));
      4: return {$urandom, $urandom};
      default: return {$urandom, 32'h8000_0000};
    endcase
  endfunction

  initial begin
    logic [63:0] res, r0, exp;
    logic [1:0] op;
    logic w, seen;
    logic [63:0] s1, s2;
    int dv0, rd0;
    tv[0] = '{2'd0, 1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    tv[1] = '{2'd2, 1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tv[2] = '{2'd3, 1'b0, 64'd7, 64'd0, 64'd7, 1'b1};
    tv[3] = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1};
    tv[4] = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b1};
    tv[5] = '{2'd0, 1'b1, 64'h1234_5678_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1};
    tv[6] = '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0};
    tv[7] = '{2'd0, 1'b0, 64'd123, 64'd0, '1, 1'b1};
    tv[8] = '{2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0};
    tv[9] = '{2'd2, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    #12;
    chk("reset_mdu_ready", {63'd0, mdu_ready_o}, 64'd1);
    chk("reset_busy", {63'd0, mdu_busy_o}, 64'd0);
    chk("reset_result_valid", {63'd0, result_valid_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_datavalid", {63'd0, div_datavalid_o}, 64'd0);
    chk("reset_div_ready", {63'd0, div_ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dv0 = dv_cnt;
      rd0 = rd_cnt;
      send(tv[i].op, tv[i].w, tv[i].s1, tv[i].s2);
      if (tv[i].sp) chk($sformatf("tv%0d_valid_T+1", i), {63'd0, result_valid_o}, 64'd1);
      get(res, 0);
      chk($sformatf("tv%0d_result", i), res, tv[i].exp);
      chk($sformatf("tv%0d_datavalid_pulses", i), 64'(dv_cnt - dv0), tv[i].sp ? 64'd0 : 64'd1);
      chk($sformatf("tv%0d_ready_pulses", i), 64'(rd_cnt - rd0), tv[i].sp ? 64'd0 : 64'd1);
    end
    // flush two cycles into WAIT with a slow divider
    force_lat = 8;
    dv0 = dv_cnt;
    rd0 = rd_cnt;
    send(2'd0, 1'b0, -64'd100, 64'd7);
    repeat (3) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (result_valid_o) seen = 1'b1;
      @(negedge clk);
    end
    force_lat = -1;
    chk("flush_no_valid", {63'd0, seen}, 64'd0);
    chk("flush_datavalid_pulses", 64'(dv_cnt - dv0), 64'd1);
    chk("flush_ready_pulses", 64'(rd_cnt - rd0), 64'd1);
    chk("flush_mdu_ready", {63'd0, mdu_ready_o}, 64'd1);
    send(2'd1, 1'b0, 64'd100, 64'd7);
    get(res, 0);
    chk("after_flush_divu", res, 64'd14);
    // backpressure in DONE
    send(2'd1, 1'b0, 64'd1000, 64'd3);
    get(r0, 0);
    chk("bp_first", r0, 64'd333);
    send(2'd0, 1'b0, -64'd1000, 64'd3);
    while (!result_valid_o) @(negedge clk);
    r0 = result_o;
    chk("bp_value", r0, -64'd333);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), {63'd0, result_valid_o}, 64'd1);
      chk($sformatf("bp_result_%0d", k), result_o, r0);
      chk($sformatf("bp_mdu_ready_%0d", k), {63'd0, mdu_ready_o}, 64'd0);
      @(negedge clk);
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    chk("bp_released", {63'd0, result_valid_o}, 64'd0);
    // asynchronous reset in WAIT
    force_lat = 8;
    send(2'd0, 1'b0, 64'd50, 64'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mdu_ready", {63'd0, mdu_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, mdu_busy_o}, 64'd0);
    chk("rst_result_valid", {63'd0, result_valid_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_datavalid", {63'd0, div_datavalid_o}, 64'd0);
    chk("rst_div_ready", {63'd0, div_ready_o}, 64'd0);
    chk("rst_dividend", div_dividend_o, 64'd0);
    chk("rst_divisor", div_divisor_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    force_lat = -1;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      s1 = pick();
      s2 = pick();
      exp = ref_op(op, w, s1, s2);
      send(op, w, s1, s2);
      get(res, int'($urandom_range(0, 2)));
      if (res !== exp) $display("  op=%0d w=%0b s1=%h s2=%h", op, w, s1, s2);
      chk($sformatf("rand%0d", i), res, exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
